// File: rtl/sap_ctrl_sequencer.sv
// Microcode sequencer for the SAP-style 8-bit CPU: T-state tracking, control-word
// decode, run/pause/single-step control, halt handling and a retired-instruction count.
//   state | meaning
//   RUN   | free-running, executes instructions back to back
//   STEP  | executes one instruction, then returns to PAUSE
//   PAUSE | idle at an instruction boundary, stage held at 0
//   HALT  | HLT retired; only reset leaves this state
module sap_ctrl_sequencer #(
    parameter bit RESET_RUN = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             flag_c,
    input  logic             flag_z,
    input  logic             run_en,
    input  logic             step,
    output logic [15:0]      ctrl_word,
    output logic [2:0]       stage,
    output logic             halted,
    output logic             paused,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [15:0] HT = 16'h0001, MI = 16'h0002, RI = 16'h0004, RO = 16'h0008;
    localparam logic [15:0] IO = 16'h0010, II = 16'h0020, AI = 16'h0040, AO = 16'h0080;
    localparam logic [15:0] EO = 16'h0100, SU = 16'h0200, BI = 16'h0400, OI = 16'h0800;
    localparam logic [15:0] CE = 16'h1000, CO = 16'h2000, JP = 16'h4000, FI = 16'h8000;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF;

    typedef enum logic [1:0] {S_RUN, S_STEP, S_PAUSE, S_HALT} state_t;

    state_t      state, state_next;
    logic [15:0] ctrl_dec;
    logic        last_step;
    logic        is_illegal;
    logic        active;
    logic        boundary;
    logic        halt_now;

    assign active     = (state == S_RUN) || (state == S_STEP);
    assign is_illegal = (opcode >= 4'h9) && (opcode <= 4'hD);
    assign boundary   = active && last_step;
    assign halt_now   = boundary && (stage == 3'd2) && (opcode == OP_HLT);

    always_comb begin
        ctrl_dec  = 16'h0000;
        last_step = 1'b0;
        case (stage)
            3'd0: ctrl_dec = CO | MI;
            3'd1: begin
                ctrl_dec  = RO | II | CE;
                last_step = (opcode == OP_NOP) || is_illegal;
            end
            3'd2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_dec = IO | MI;
                    OP_LDI: begin ctrl_dec = IO | AI; last_step = 1'b1; end
                    OP_JMP: begin ctrl_dec = IO | JP; last_step = 1'b1; end
                    OP_JC:  begin ctrl_dec = flag_c ? (IO | JP) : 16'h0000; last_step = 1'b1; end
                    OP_JZ:  begin ctrl_dec = flag_z ? (IO | JP) : 16'h0000; last_step = 1'b1; end
                    OP_OUT: begin ctrl_dec = AO | OI; last_step = 1'b1; end
                    OP_HLT: begin ctrl_dec = HT; last_step = 1'b1; end
                    default: ctrl_dec = 16'h0000;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA:         begin ctrl_dec = RO | AI; last_step = 1'b1; end
                    OP_ADD, OP_SUB: ctrl_dec = RO | BI;
                    OP_STA:         begin ctrl_dec = AO | RI; last_step = 1'b1; end
                    default:        ctrl_dec = 16'h0000;
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_ADD:  begin ctrl_dec = EO | AI | FI; last_step = 1'b1; end
                    OP_SUB:  begin ctrl_dec = EO | AI | FI | SU; last_step = 1'b1; end
                    default: ctrl_dec = 16'h0000;
                endcase
            end
            default: ctrl_dec = 16'h0000;
        endcase
    end

    // Control word is only live while an instruction is executing and reset is low.
    assign ctrl_word = (active && !reset) ? ctrl_dec : 16'h0000;
    assign halted    = (state == S_HALT);
    assign paused    = (state == S_PAUSE);

    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (boundary) begin
                    if (halt_now)     state_next = S_HALT;
                    else if (!run_en) state_next = S_PAUSE;
                end
            end
            S_STEP: begin
                if (boundary) state_next = halt_now ? S_HALT : S_PAUSE;
            end
            S_PAUSE: begin
                if (run_en)    state_next = S_RUN;
                else if (step) state_next = S_STEP;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_PAUSE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RESET_RUN ? S_RUN : S_PAUSE;
            stage      <= 3'd0;
            instr_done <= 1'b0;
            illegal    <= 1'b0;
            retired    <= '0;
        end else begin
            state      <= state_next;
            instr_done <= boundary;
            if (!active || last_step) stage <= 3'd0;
            else                      stage <= stage + 3'd1;
            if (boundary) retired <= retired + CNT_W'(1);
            if (boundary && (stage == 3'd1) && is_illegal) illegal <= 1'b1;
        end
    end

endmodule
